demux_1to2_reg: RTL and testbench
=================================

DEMUX_1TO2_REG -- requirements
Module: demux_1to2_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of every data port.
REQ-002 SHALL have one clock and an asynchronous, active-low reset. Port clk, input, 1 bit, rising-edge clock.
REQ-003 SHALL have rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have in_valid, input, 1 bit, producer offers a word.
REQ-005 SHALL have in_ready, output, 1 bit, block accepts the word this cycle.
REQ-006 SHALL have in_data, input, WIDTH bits, offered word.
REQ-007 SHALL have in_select, input, 1 bit, destination (0 -> port 0, 1 -> port 1), qualified by in_valid.
REQ-008 SHALL have flush, input, 1 bit, synchronous discard of all buffered words.
REQ-009 SHALL have out0_valid (output, 1), out0_ready (input, 1) and out0_data (output, WIDTH) as the destination-0 handshake.
REQ-010 SHALL have out1_valid (output, 1), out1_ready (input, 1) and out1_data (output, WIDTH) as the destination-1 handshake.

Function
REQ-011 SHALL hold one 2-entry FIFO per destination; outN_valid = FIFO N non-empty; outN_data = FIFO N head, driven from flops only.
REQ-012 SHALL compute in_ready = !flush && (FIFO[in_select] count < 2); in_ready depends only on state, flush and in_select, never on outN_ready.
REQ-013 SHALL enqueue in_data into FIFO[in_select] on a clock edge where in_valid && in_ready; latency from accept to outN_valid SHALL be 1 cycle.
REQ-014 SHALL dequeue the FIFO N head on an edge where outN_valid && outN_ready.
REQ-015 SHALL, on simultaneous enqueue and dequeue on the same FIFO, keep the count unchanged and preserve order; at count 2 the enqueue is refused (in_ready=0) even when a dequeue occurs the same cycle.
REQ-016 SHALL preserve FIFO order per destination; no ordering is guaranteed between destinations.
REQ-017 SHALL sustain one word per cycle to a single destination when its consumer holds ready high.
REQ-018 SHALL, when flush=1, set both counts to 0 on the next edge, ignore any enqueue and dequeue that cycle, and drive in_ready=0.
REQ-019 SHALL keep outN_data and outN_valid stable while outN_valid && !outN_ready.
REQ-020 SHALL use wrap-around 1-bit read/write pointers and a 2-bit count per FIFO; count SHALL never exceed 2 or underflow below 0.
REQ-021 SHALL ignore in_select and in_data when in_valid=0.

Reset
REQ-022 SHALL, on rst_n low, asynchronously clear both counts and pointers, so out0_valid=0 and out1_valid=0 immediately.
REQ-023 SHALL reset out0_data and out1_data storage to 0.
REQ-024 SHALL drop any words buffered when reset asserts mid-operation; the first accept after rst_n deasserts SHALL be the first word output.

Structure
REQ-025 SHALL import WIDTH default (32), FIFO depth constant (2) and the destination-select encoding from the shared processor package.
REQ-026 SHALL instantiate one sub-module, fifo2_reg, twice (one per destination); selection logic lives in the top level.

Verification
REQ-027 SHALL cover this reset case: rst_n=0 with both FIFOs full -> out0_valid=out1_valid=0 immediately; after release, in_ready=1 for both selects.
REQ-028 SHALL cover this sequencing case: words 0xA1, 0xA2, 0xA3 sent with select 0 while out0_ready=0 -> in_ready=0 on the third word; raising out0_ready yields 0xA1 then 0xA2, then 0xA3 is accepted.
REQ-029 SHALL cover this interleaving case: 0x10 (sel 0) and 0x20 (sel 1) interleaved, out1_ready=1, out0_ready=0 -> 0x20 appears one cycle after accept; FIFO 1 is not blocked by full FIFO 0.
REQ-030 SHALL cover this streaming case: 100 words to destination 1 with out1_ready held high -> one word per cycle, in order, no bubbles after the first.
REQ-031 SHALL cover this flush case: flush with 2 words in FIFO 0 and 1 in FIFO 1, plus in_valid=1 -> next cycle both outN_valid=0 and the offered word is not accepted.
REQ-032 SHALL cover this same-edge case: FIFO 0 at count 1 with enqueue and dequeue on the same edge -> count stays 1 and the new word becomes the head.

Source files
------------

// File: rtl/demux_1to2_reg_pkg.sv
// Shared definitions for the registered 1-to-2 demultiplexer: default data
// width, per-destination FIFO depth and the destination-select encoding.
package demux_1to2_reg_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Depth of each per-destination FIFO, sized to match the 2-bit occupancy count
  localparam logic [1:0] FIFO_DEPTH = 2'd2;

  typedef enum logic {
    DEST_PORT0 = 1'b0,
    DEST_PORT1 = 1'b1
  } dest_sel_e;

  // True while a FIFO holding 'count' words can take one more
  function automatic logic has_room(input logic [1:0] count);
    return count < FIFO_DEPTH;
  endfunction

endpackage

// File: rtl/fifo2_reg.sv
// Two-entry flop-based FIFO with wrap-around 1-bit pointers, a 2-bit count,
// synchronous flush and asynchronous active-low reset. The head word is
// read straight out of the storage flops.
module fifo2_reg
  import demux_1to2_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [0:1];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt;
  logic             do_push;
  logic             do_pop;

  // Guard both operations so the count can never overflow or underflow
  always_comb begin
    do_push = push && has_room(cnt);
    do_pop  = pop && (cnt != 2'd0);
  end

  // Pointer and occupancy bookkeeping; flush wins over any push or pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Word storage, cleared on reset and written only by an accepted push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (!flush && do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign valid = (cnt != 2'd0);
  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/demux_1to2_reg.sv
// Registered 1-to-2 demultiplexer: each accepted input word is steered by
// in_select into one of two independent 2-entry FIFOs, each with its own
// valid/ready output handshake. Acceptance depends only on the selected
// FIFO's occupancy and flush, never on the downstream ready signals.
module demux_1to2_reg
  import demux_1to2_reg_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_select,
  input  logic             flush,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
);

  dest_sel_e  dest;
  logic [1:0] count0;
  logic [1:0] count1;
  logic [1:0] sel_count;
  logic       accept;
  logic       push0;
  logic       push1;
  logic       pop0;
  logic       pop1;

  assign dest = dest_sel_e'(in_select);

  // Steer the offered word to the selected FIFO and derive the handshakes
  always_comb begin
    sel_count = (dest == DEST_PORT1) ? count1 : count0;
    in_ready  = !flush && has_room(sel_count);
    accept    = in_valid && in_ready;
    push0     = accept && (dest == DEST_PORT0);
    push1     = accept && (dest == DEST_PORT1);
    pop0      = out0_valid && out0_ready;
    pop1      = out1_valid && out1_ready;
  end

  fifo2_reg #(
    .WIDTH (WIDTH)
  ) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push0),
    .push_data (in_data),
    .pop       (pop0),
    .valid     (out0_valid),
    .head      (out0_data),
    .count     (count0)
  );

  fifo2_reg #(
    .WIDTH (WIDTH)
  ) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push1),
    .push_data (in_data),
    .pop       (pop1),
    .valid     (out1_valid),
    .head      (out1_data),
    .count     (count1)
  );

endmodule

// File: tb/tb_demux_1to2_reg.sv
// Scoreboard bench for demux_1to2_reg. The stimulus side keeps a queue model
// of each destination FIFO, predicts in_ready/valid/head every cycle and
// pushes accepted words into per-destination scoreboards; an independent
// monitor pops and compares whenever the DUT completes an output handshake.
module tb_demux_1to2_reg;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_select;
  logic             flush;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;

  int checks = 0;
  int errors = 0;
  int pops0  = 0;
  int pops1  = 0;

  logic [WIDTH-1:0] model0[$];
  logic [WIDTH-1:0] model1[$];
  logic [WIDTH-1:0] sb0[$];
  logic [WIDTH-1:0] sb1[$];

  demux_1to2_reg #(
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_select  (in_select),
    .flush      (flush),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkFlag(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0b, expected %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check the DUT against the model, then advance the model
  task automatic applyStimulus(input logic v, input logic sel, input logic [WIDTH-1:0] data,
                               input logic r0, input logic r1, input logic fl,
                               output logic accepted);
    logic exp_ready;
    @(negedge clk);
    in_valid   = v;
    in_select  = sel;
    in_data    = data;
    out0_ready = r0;
    out1_ready = r1;
    flush      = fl;
    #1;
    exp_ready = !fl && ((sel ? model1.size() : model0.size()) < 2);
    checkFlag("in_ready", in_ready, exp_ready);
    checkFlag("out0_valid", out0_valid, model0.size() != 0);
    checkFlag("out1_valid", out1_valid, model1.size() != 0);
    if (model0.size() != 0) checkOutput("out0_data head", out0_data, model0[0]);
    if (model1.size() != 0) checkOutput("out1_data head", out1_data, model1[0]);
    accepted = v && exp_ready;
    if (fl) begin
      model0.delete();
      model1.delete();
      sb0.delete();
      sb1.delete();
    end else begin
      if (r0 && model0.size() != 0) void'(model0.pop_front());
      if (r1 && model1.size() != 0) void'(model1.pop_front());
      if (accepted) begin
        if (sel) begin
          model1.push_back(data);
          sb1.push_back(data);
        end else begin
          model0.push_back(data);
          sb0.push_back(data);
        end
      end
    end
  endtask

  task automatic drain(input int cycles);
    logic acc;
    for (int i = 0; i < cycles; i++) applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, acc);
  endtask

  // Monitor: compare every completed output handshake against the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && !flush) begin
        if (out0_valid && out0_ready) begin
          if (sb0.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL out0 scoreboard: got handshake with 0 queued words, expected >=1");
          end else begin
            checkOutput("out0 data order", out0_data, sb0.pop_front());
          end
          pops0++;
        end
        if (out1_valid && out1_ready) begin
          if (sb1.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL out1 scoreboard: got handshake with 0 queued words, expected >=1");
          end else begin
            checkOutput("out1 data order", out1_data, sb1.pop_front());
          end
          pops1++;
        end
      end
    end
  end

  // Directed scenarios followed by a randomized soak
  initial begin
    logic acc;
    int   n_acc;
    int   start_pops;

    rst_n = 1'b0;
    in_valid = 1'b0; in_select = 1'b0; in_data = '0; flush = 1'b0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checkFlag("reset out0_valid", out0_valid, 1'b0);
    checkFlag("reset out1_valid", out1_valid, 1'b0);
    checkOutput("reset out0_data", out0_data, '0);
    checkOutput("reset out1_data", out1_data, '0);
    #1 rst_n = 1'b1;

    $display("[TB] sequencing: three words to a stalled port 0");
    applyStimulus(1'b1, 1'b0, 32'hA1, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b0, 32'hA2, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b0, 32'hA3, 1'b0, 1'b0, 1'b0, acc);
    acc = 1'b0;
    for (int i = 0; i < 4 && !acc; i++) applyStimulus(1'b1, 1'b0, 32'hA3, 1'b1, 1'b0, 1'b0, acc);
    drain(4);

    $display("[TB] interleaving: port 1 flows while port 0 is full");
    applyStimulus(1'b1, 1'b0, 32'h10, 1'b0, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 32'h20, 1'b0, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 1'b0, 32'h11, 1'b0, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 32'h21, 1'b0, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 1'b0, 32'h12, 1'b0, 1'b1, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 32'h22, 1'b0, 1'b1, 1'b0, acc);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, acc);
    drain(4);

    $display("[TB] streaming: 100 words to port 1");
    start_pops = pops1;
    n_acc = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h1000 + i, 1'b0, 1'b1, 1'b0, acc);
      if (acc) n_acc++;
    end
    drain(2);
    checkOutput("stream words delivered", 32'(pops1 - start_pops), 32'(n_acc));
    checkOutput("stream delivered count", 32'(pops1 - start_pops), 32'd100);

    $display("[TB] flush with both FIFOs occupied and a word offered");
    applyStimulus(1'b1, 1'b0, 32'hB1, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b0, 32'hB2, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 32'hC1, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 32'hC2, 1'b1, 1'b1, 1'b1, acc);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
    drain(2);

    $display("[TB] same-edge enqueue and dequeue at count 1");
    applyStimulus(1'b1, 1'b0, 32'hD1, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b0, 32'hD2, 1'b1, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
    drain(3);

    $display("[TB] asynchronous reset with both FIFOs full");
    applyStimulus(1'b1, 1'b0, 32'hE1, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b0, 32'hE2, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 32'hF1, 1'b0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 1'b1, 32'hF2, 1'b0, 1'b0, 1'b0, acc);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkFlag("async reset out0_valid", out0_valid, 1'b0);
    checkFlag("async reset out1_valid", out1_valid, 1'b0);
    checkOutput("async reset out0_data", out0_data, '0);
    checkOutput("async reset out1_data", out1_data, '0);
    model0.delete(); model1.delete(); sb0.delete(); sb1.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    in_select = 1'b0;
    #1 checkFlag("post-reset in_ready sel0", in_ready, 1'b1);
    in_select = 1'b1;
    #1 checkFlag("post-reset in_ready sel1", in_ready, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h5A, 1'b1, 1'b1, 1'b0, acc);
    drain(2);

    $display("[TB] randomized soak");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom(),
                    1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 3) == 0),
                    1'($urandom_range(0, 63) == 0), acc);
    end
    drain(6);
    checkOutput("sb0 drained", 32'(sb0.size()), 32'd0);
    checkOutput("sb1 drained", 32'(sb1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
